// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl: debounced step/mode buttons driving a stretched manual clock and the auto_en select
//
// Ports:
//   raw_clk    in   board clock, the only clock in this block
//   rst        in   asynchronous active-low reset
//   btn_step   in   raw step button, bouncing, 1 = pressed
//   btn_mode   in   raw mode button, bouncing, 1 = pressed
//   burst_len  in   pulses per step press (burst build only), 0 behaves as 1
//   manual_clk out  registered manual clock
//   auto_en    out  1 = manual stepping, 0 = divider free-runs
//   busy       out  1 while a pulse or burst is in progress
//   step_cnt   out  total manual pulses issued, wraps at 16'hFFFF
//
// Build option: define CLK_STEP_BURST_EN to let one step press emit burst_len pulses;
// without it every accepted press emits exactly one pulse.
module clk_step_ctrl #(
  parameter int DB_CYCLES   = 20000,
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic        raw_clk,
  input  logic        rst,
  input  logic        btn_step,
  input  logic        btn_mode,
  input  logic [7:0]  burst_len,
  output logic        manual_clk,
  output logic        auto_en,
  output logic        busy,
  output logic [15:0] step_cnt
);
  localparam int CW   = $clog2(DB_CYCLES) + 1;
  localparam int PMAX = HIGH_CYCLES > GAP_CYCLES ? HIGH_CYCLES : GAP_CYCLES;
  localparam int PW   = $clog2(PMAX) + 1;
`ifdef CLK_STEP_BURST_EN
  localparam int RW = 8;
`else
  localparam int RW = 1;
`endif

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  // Bit 0 is the step button, bit 1 the mode button throughout.
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          stable_q, stable_d;
  logic [1:0]          press_q, press_d;
  logic [1:0][CW-1:0]  db_cnt_q, db_cnt_d;
  state_t              state_q, state_d;
  logic [PW-1:0]       ph_q, ph_d;
  logic [RW-1:0]       rem_q, rem_d, rem_load;
  logic                manual_clk_q, manual_clk_d;
  logic                auto_en_q, auto_en_d;
  logic                busy_q, busy_d;
  logic [15:0]         step_cnt_q, step_cnt_d;

`ifdef CLK_STEP_BURST_EN
  assign rem_load = (burst_len == 8'd0) ? 8'd1 : burst_len;
`else
  // Single-pulse build: rem degenerates to one done bit and burst_len is ignored.
  logic unused_burst_len;
  assign unused_burst_len = ^burst_len;
  assign rem_load = 1'b1;
`endif

  // A level change is accepted only after DB_CYCLES consecutive mismatching cycles.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      stable_d[i] = (sync2_q[i] != stable_q[i] && db_cnt_q[i] == CW'(DB_CYCLES - 1)) ? sync2_q[i] : stable_q[i];
      db_cnt_d[i] = (sync2_q[i] != stable_q[i] && db_cnt_q[i] != CW'(DB_CYCLES - 1)) ? db_cnt_q[i] + CW'(1) : '0;
    end
    press_d = stable_d & ~stable_q;
  end

  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    rem_d        = rem_q;
    manual_clk_d = manual_clk_q;
    auto_en_d    = auto_en_q;
    busy_d       = busy_q;
    step_cnt_d   = step_cnt_q;
    unique case (state_q)
      IDLE: begin
        // Mode has priority; a step arriving with it is dropped.
        if (press_q[1]) begin
          auto_en_d = ~auto_en_q;
        end else if (press_q[0] && auto_en_q) begin
          state_d      = HIGH;
          ph_d         = '0;
          rem_d        = rem_load;
          manual_clk_d = 1'b1;
          busy_d       = 1'b1;
          step_cnt_d   = step_cnt_q + 16'd1;
        end
      end
      HIGH: begin
        if (ph_q == PW'(HIGH_CYCLES - 1)) begin
          state_d      = GAP;
          ph_d         = '0;
          rem_d        = rem_q - RW'(1);
          manual_clk_d = 1'b0;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      GAP: begin
        if (ph_q == PW'(GAP_CYCLES - 1)) begin
          ph_d = '0;
          if (rem_q != '0) begin
            state_d      = HIGH;
            manual_clk_d = 1'b1;
            step_cnt_d   = step_cnt_q + 16'd1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      default: begin
        state_d      = IDLE;
        manual_clk_d = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
    manual_clk_d = manual_clk_d & auto_en_d;
  end

  always_ff @(posedge raw_clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      press_q      <= '0;
      db_cnt_q     <= '0;
      state_q      <= IDLE;
      ph_q         <= '0;
      rem_q        <= '0;
      manual_clk_q <= 1'b0;
      auto_en_q    <= 1'b1;
      busy_q       <= 1'b0;
      step_cnt_q   <= '0;
    end else begin
      sync1_q      <= {btn_mode, btn_step};
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      press_q      <= press_d;
      db_cnt_q     <= db_cnt_d;
      state_q      <= state_d;
      ph_q         <= ph_d;
      rem_q        <= rem_d;
      manual_clk_q <= manual_clk_d;
      auto_en_q    <= auto_en_d;
      busy_q       <= busy_d;
      step_cnt_q   <= step_cnt_d;
    end
  end

  assign manual_clk = manual_clk_q;
  assign auto_en    = auto_en_q;
  assign busy       = busy_q;
  assign step_cnt   = step_cnt_q;
endmodule

// File: tb/tb_clk_step_ctrl.sv
// tb_clk_step_ctrl: randomized and directed checks of clk_step_ctrl against a schedule-based model
module tb_clk_step_ctrl;
  localparam int DB = 4;
  localparam int H  = 4;
  localparam int G  = 4;
  localparam int P  = H + G;
`ifdef CLK_STEP_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        raw_clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_step = 1'b0;
  logic        btn_mode = 1'b0;
  logic [7:0]  burst_len = 8'd1;
  logic        manual_clk, auto_en, busy;
  logic [15:0] step_cnt;

  clk_step_ctrl #(.DB_CYCLES(DB), .HIGH_CYCLES(H), .GAP_CYCLES(G)) dut (
    .raw_clk(raw_clk), .rst(rst), .btn_step(btn_step), .btn_mode(btn_mode),
    .burst_len(burst_len), .manual_clk(manual_clk), .auto_en(auto_en),
    .busy(busy), .step_cnt(step_cnt)
  );

  always #5 raw_clk = ~raw_clk;

  int tests = 0;
  int fails = 0;
  int hi_tot = 0;
  int busy_tot = 0;

  // Model: button path as delay line + debounce rule; pulse train as an arithmetic schedule
  // indexed by k = cycles since the accepting edge.
  logic [1:0]  ms1, ms2, mst, mpress;
  int          mc [2];
  logic        m_auto, m_act;
  int          m_k, m_n;
  logic [15:0] m_base;

  function automatic logic m_busy();
    return m_act && (m_k < m_n * P);
  endfunction

  function automatic logic m_man();
    return m_busy() && ((m_k % P) < H);
  endfunction

  function automatic logic [15:0] m_cnt();
    int p;
    if (!m_act) return m_base;
    p = m_k / P + 1;
    if (p > m_n) p = m_n;
    return m_base + 16'(p);
  endfunction

  task automatic model_reset();
    ms1 = '0; ms2 = '0; mst = '0; mpress = '0;
    mc[0] = 0; mc[1] = 0;
    m_auto = 1'b1; m_act = 1'b0; m_k = 0; m_n = 1; m_base = '0;
  endtask

  task automatic model_step();
    logic [1:0] old;
    if (!m_busy()) begin
      if (mpress[1]) m_auto = ~m_auto;
      else if (mpress[0] && m_auto) begin
        m_base = m_cnt();
        m_act  = 1'b1;
        m_k    = 0;
        m_n    = BURST ? ((burst_len == 8'd0) ? 1 : int'(burst_len)) : 1;
      end
    end else m_k++;
    old = mst;
    for (int b = 0; b < 2; b++) begin
      if (ms2[b] == mst[b]) mc[b] = 0;
      else begin
        mc[b]++;
        if (mc[b] == DB) begin
          mst[b] = ms2[b];
          mc[b]  = 0;
        end
      end
    end
    mpress = mst & ~old;
    ms2 = ms1;
    ms1 = {btn_mode, btn_step};
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge raw_clk);
    if (rst) model_step();
    @(negedge raw_clk);
    if (rst) begin
      chk("manual_clk", 16'(manual_clk), 16'(m_man()));
      chk("auto_en", 16'(auto_en), 16'(m_auto));
      chk("busy", 16'(busy), 16'(m_busy()));
      chk("step_cnt", step_cnt, m_cnt());
    end
    hi_tot   += int'(manual_clk);
    busy_tot += int'(busy);
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  // Press one or both buttons with a short random bounce before the solid hold.
  task automatic pulse(input bit s, input bit m, input int hold);
    int nb;
    logic v;
    nb = $urandom_range(0, 3);
    for (int i = 0; i < nb; i++) begin
      v = 1'($urandom_range(0, 1));
      btn_step = s & v;
      btn_mode = m & v;
      tick();
    end
    btn_step = s;
    btn_mode = m;
    wait_n(hold);
    btn_step = 1'b0;
    btn_mode = 1'b0;
  endtask

  int h0, b0;
  logic [15:0] c0;

  initial begin
    model_reset();
    repeat (3) @(negedge raw_clk);
    rst = 1'b1;
    chk("reset_manual_clk", 16'(manual_clk), 16'd0);
    chk("reset_auto_en", 16'(auto_en), 16'd1);
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_step_cnt", step_cnt, 16'd0);

    // Too-short press is filtered, a solid press gives one 4-high pulse and 8 busy cycles.
    burst_len = 8'd1;
    h0 = hi_tot;
    btn_step = 1'b1;
    wait_n(2);
    btn_step = 1'b0;
    wait_n(20);
    chk("short_press_cnt", step_cnt, 16'd0);
    chk("short_press_hi", 16'(hi_tot - h0), 16'd0);
    h0 = hi_tot; b0 = busy_tot;
    btn_step = 1'b1;
    wait_n(12);
    btn_step = 1'b0;
    wait_n(20);
    chk("single_cnt", step_cnt, 16'd1);
    chk("single_hi", 16'(hi_tot - h0), 16'd4);
    chk("single_busy", 16'(busy_tot - b0), 16'd8);

    // Burst of 3; burst_len changed after acceptance must not matter.
    burst_len = 8'd3;
    h0 = hi_tot; b0 = busy_tot; c0 = step_cnt;
    pulse(1'b1, 1'b0, 12);
    burst_len = 8'd7;
    wait_n(40);
    chk("burst3_hi", 16'(hi_tot - h0), BURST ? 16'd12 : 16'd4);
    chk("burst3_busy", 16'(busy_tot - b0), BURST ? 16'd24 : 16'd8);
    chk("burst3_cnt", step_cnt - c0, BURST ? 16'd3 : 16'd1);
    burst_len = 8'd0;
    h0 = hi_tot; c0 = step_cnt;
    pulse(1'b1, 1'b0, 12);
    wait_n(30);
    chk("burst0_hi", 16'(hi_tot - h0), 16'd4);
    chk("burst0_cnt", step_cnt - c0, 16'd1);

    // Mode toggling and step rejection while free-running.
    burst_len = 8'd2;
    pulse(1'b0, 1'b1, 10);
    wait_n(20);
    chk("mode_off", 16'(auto_en), 16'd0);
    h0 = hi_tot; c0 = step_cnt;
    pulse(1'b1, 1'b0, 10);
    wait_n(30);
    chk("step_in_auto_cnt", step_cnt - c0, 16'd0);
    chk("step_in_auto_hi", 16'(hi_tot - h0), 16'd0);
    pulse(1'b0, 1'b1, 10);
    wait_n(20);
    chk("mode_on", 16'(auto_en), 16'd1);

    // Mode press (and, in burst build, a second step press) landing inside a running burst.
    burst_len = 8'd3;
    c0 = step_cnt;
    for (int c = 0; c < 60; c++) begin
      btn_step = (c < 12) || (BURST && c >= 18 && c < 30);
      btn_mode = (c >= 2) && (c < 14);
      tick();
    end
    btn_step = 1'b0; btn_mode = 1'b0;
    wait_n(20);
    chk("mode_in_burst", 16'(auto_en), 16'd1);
    chk("burst_no_extra", step_cnt - c0, BURST ? 16'd3 : 16'd1);

    // Simultaneous mode and step events: mode wins.
    c0 = step_cnt;
    pulse(1'b1, 1'b1, 10);
    wait_n(30);
    chk("both_auto_en", 16'(auto_en), 16'd0);
    chk("both_cnt", step_cnt - c0, 16'd0);
    pulse(1'b0, 1'b1, 10);
    wait_n(20);

    // Asynchronous reset in the middle of a burst.
    burst_len = 8'd2;
    btn_step = 1'b1;
    wait_n(9);
    chk("pre_reset_busy", 16'(busy), 16'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_manual_clk", 16'(manual_clk), 16'd0);
    chk("async_auto_en", 16'(auto_en), 16'd1);
    chk("async_busy", 16'(busy), 16'd0);
    chk("async_step_cnt", step_cnt, 16'd0);
    model_reset();
    btn_step = 1'b0;
    wait_n(2);
    rst = 1'b1;
    h0 = hi_tot;
    wait_n(20);
    chk("post_reset_hi", 16'(hi_tot - h0), 16'd0);
    chk("post_reset_cnt", step_cnt, 16'd0);

    // Randomized presses with bounce, short holds and overlapping activity.
    repeat (60) begin
      int op;
      burst_len = 8'($urandom_range(0, 4));
      op = $urandom_range(0, 3);
      pulse(op != 1, op == 1 || op == 2, $urandom_range(1, 12));
      burst_len = 8'($urandom_range(0, 15));
      wait_n((op == 3) ? $urandom_range(0, 6) : $urandom_range(5, 30));
    end
    wait_n(150);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
